fifo_flex: RTL and testbench



---
 rtl/fifo_flex_if.sv | 14 +
 rtl/fifo_flex.sv | 94 +++++++++
 tb/tb_fifo_flex.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/fifo_flex_if.sv
// Stream handshake bundle for fifo_flex: producer/consumer side (master)
// and the FIFO side (slave).
interface fifo_flex_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  wr;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  rd;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;

  modport master (output wr, w_data, rd, input r_data, r_valid);
  modport slave  (input wr, w_data, rd, output r_data, r_valid);
endinterface

// File: rtl/fifo_flex.sv
// Single-clock FIFO with selectable FWFT/registered read, programmable
// almost flags, occupancy count, synchronous flush and sticky error flags.
module fifo_flex #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = 1,
  parameter int AF_TH      = 2**ADDR_WIDTH - 2,
  parameter int AE_TH      = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  fifo_flex_if.slave          bus,
  input  logic                flush,
  input  logic                clr_err,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [ADDR_WIDTH:0] count,
  output logic                overflow,
  output logic                underflow
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_TH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_TH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] w_ptr, r_ptr;
  logic [ADDR_WIDTH:0]   cnt;
  logic                  rd_acc, wr_acc, wr_rej, rd_rej;

  assign count        = cnt;
  assign empty        = (cnt == '0);
  assign full         = (cnt == DEPTH_C);
  assign almost_full  = (cnt >= AF_C);
  assign almost_empty = (cnt <= AE_C);

  // Flush cycle swallows both requests and must not raise error flags.
  assign rd_acc = bus.rd & ~empty & ~flush;
  assign wr_acc = bus.wr & (~full | rd_acc) & ~flush;
  assign wr_rej = bus.wr & ~flush & ~wr_acc;
  assign rd_rej = bus.rd & ~flush & ~rd_acc;

  always_ff @(posedge clk) begin
    if (wr_acc) mem[w_ptr] <= bus.w_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (flush) begin
        w_ptr <= '0;
        r_ptr <= '0;
        cnt   <= '0;
      end else begin
        if (wr_acc) w_ptr <= w_ptr + ADDR_WIDTH'(1);
        if (rd_acc) r_ptr <= r_ptr + ADDR_WIDTH'(1);
        case ({wr_acc, rd_acc})
          2'b10:   cnt <= cnt + (ADDR_WIDTH+1)'(1);
          2'b01:   cnt <= cnt - (ADDR_WIDTH+1)'(1);
          default: cnt <= cnt;
        endcase
      end
      // A new error in the clearing cycle wins over clr_err.
      overflow  <= wr_rej | (overflow  & ~clr_err);
      underflow <= rd_rej | (underflow & ~clr_err);
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign bus.r_data  = mem[r_ptr];
    assign bus.r_valid = ~empty;
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvalid_q;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= rd_acc;
        if (rd_acc) rdata_q <= mem[r_ptr];
      end
    end
    assign bus.r_data  = rdata_q;
    assign bus.r_valid = rvalid_q;
  end
endmodule

// File: tb/tb_fifo_flex.sv
// Drives a FWFT and a registered-read DEPTH=4 fifo_flex with identical
// stimulus and compares both against a queue-based reference model.
module tb_fifo_flex;
  localparam int DEPTH = 4;

  logic clk, reset_n;
  logic wr, rd, flush, clr_err;
  logic [7:0] wd;

  fifo_flex_if #(.DATA_WIDTH(8)) b1 ();
  fifo_flex_if #(.DATA_WIDTH(8)) b0 ();
  assign b1.wr = wr; assign b1.rd = rd; assign b1.w_data = wd;
  assign b0.wr = wr; assign b0.rd = rd; assign b0.w_data = wd;

  logic       full1, empty1, af1, ae1, ovf1, udf1;
  logic       full0, empty0, af0, ae0, ovf0, udf0;
  logic [2:0] cnt1, cnt0;

  fifo_flex #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(b1), .flush(flush), .clr_err(clr_err),
    .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(cnt1), .overflow(ovf1), .underflow(udf1));

  fifo_flex #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(b0), .flush(flush), .clr_err(clr_err),
    .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(cnt0), .overflow(ovf0), .underflow(udf0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [7:0] q[$];
  bit         m_of, m_uf, m_rv;
  logic [7:0] m_rd;
  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int sz;
    sz = q.size();
    chk("cnt1", 32'(cnt1), 32'(sz));   chk("cnt0", 32'(cnt0), 32'(sz));
    chk("full1", 32'(full1), 32'(sz == DEPTH)); chk("full0", 32'(full0), 32'(sz == DEPTH));
    chk("empty1", 32'(empty1), 32'(sz == 0));   chk("empty0", 32'(empty0), 32'(sz == 0));
    chk("af1", 32'(af1), 32'(sz >= DEPTH-2));   chk("af0", 32'(af0), 32'(sz >= DEPTH-2));
    chk("ae1", 32'(ae1), 32'(sz <= 1));         chk("ae0", 32'(ae0), 32'(sz <= 1));
    chk("ovf1", 32'(ovf1), 32'(m_of)); chk("ovf0", 32'(ovf0), 32'(m_of));
    chk("udf1", 32'(udf1), 32'(m_uf)); chk("udf0", 32'(udf0), 32'(m_uf));
    chk("rvalid1", 32'(b1.r_valid), 32'(sz != 0));
    if (sz != 0) chk("rdata1", 32'(b1.r_data), 32'(q[0]));
    chk("rvalid0", 32'(b0.r_valid), 32'(m_rv));
    chk("rdata0", 32'(b0.r_data), 32'(m_rd));
  endtask

  task automatic model_reset();
    q.delete();
    m_of = 0; m_uf = 0; m_rv = 0; m_rd = 8'h00;
  endtask

  // one clock: apply inputs, advance model by the FIFO rules, check after edge
  task automatic step(input bit w, input logic [7:0] d, input bit r,
                      input bit f = 0, input bit c = 0);
    bit racc, wacc;
    wr = w; wd = d; rd = r; flush = f; clr_err = c;
    @(posedge clk);
    if (f) begin
      q.delete();
      m_rv = 0;
      m_of = m_of && !c;
      m_uf = m_uf && !c;
    end else begin
      racc = r && (q.size() > 0);
      wacc = w && ((q.size() < DEPTH) || racc);
      m_of = (w && !wacc) || (m_of && !c);
      m_uf = (r && !racc) || (m_uf && !c);
      m_rv = racc;
      if (racc) m_rd = q.pop_front();
      if (wacc) q.push_back(d);
    end
    #1;
    check_all();
  endtask

  // asynchronous reset mid-cycle, checked before the next edge
  task automatic async_reset();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    #2 reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; wr = 0; rd = 0; flush = 0; clr_err = 0; wd = 8'h00;
    model_reset();
    @(posedge clk); #1;
    check_all();
    reset_n = 1'b1;

    // fill, then drain in order
    step(1, 8'h11, 0); step(1, 8'h22, 0); step(1, 8'h33, 0); step(1, 8'h44, 0);
    // write+read while full: accepted, no overflow
    step(1, 8'h55, 1);
    // write alone while full: rejected, sticky overflow until clr_err
    step(1, 8'h66, 0); step(0, 8'h00, 0); step(0, 8'h00, 0, 0, 1);
    repeat (5) step(0, 8'h00, 1);   // last read hits empty -> underflow
    step(1, 8'hA5, 1);              // read on empty + write: count 0->1
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 1);
    // registered-read pulses and hold
    step(1, 8'h10, 0); step(1, 8'h20, 0);
    step(0, 8'h00, 1); step(0, 8'h00, 1); step(0, 8'h00, 0); step(0, 8'h00, 0);
    // wrap-around with incrementing pattern
    for (int i = 0; i < 10; i++) begin
      step(1, 8'(8'h80 + 2*i), 0);
      step(1, 8'(8'h81 + 2*i), 1);
    end
    while (q.size() > 0) step(0, 8'h00, 1);
    // flush with wr=1 and rd=1 sets nothing
    step(1, 8'h01, 0); step(1, 8'h02, 0); step(1, 8'h03, 0);
    step(1, 8'h04, 1, 1, 0);
    step(0, 8'h00, 1, 1, 0);   // read on empty during flush: no underflow
    step(1, 8'h07, 0); step(1, 8'h08, 0);
    async_reset();

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 9) < 5,
           $urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0);
    step(1, 8'h3C, 0);
    async_reset();
    for (int i = 0; i < 100; i++)
      step($urandom_range(0, 9) < 4, 8'($urandom), $urandom_range(0, 9) < 6,
           1'b0, $urandom_range(0, 9) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
